// File: rtl/regfile_sb.sv
// Multi-port GPR file with write-to-read bypass, HI/LO pair, and a per-register
// pending-write scoreboard that tracks in-flight destinations between issue and writeback.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  input  logic                     flush,
  input  logic                     hi_we,
  input  logic                     lo_we,
  input  logic [DATA_W-1:0]        hi_wdata,
  input  logic [DATA_W-1:0]        lo_wdata,
  output logic [DATA_W-1:0]        hi_rdata,
  output logic [DATA_W-1:0]        lo_rdata,
  output logic                     sb_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   ONE     = (CNT_W+1)'(1);

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [CNT_W-1:0]  cnt     [DEPTH];
  logic [CNT_W-1:0]  cnt_nxt [DEPTH];
  logic [CNT_W:0]    dec     [DEPTH];
  logic [ADDR_W-1:0] wa      [NUM_WR];
  logic [DATA_W-1:0] wd      [NUM_WR];
  logic [NUM_WR-1:0] wr_act;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              err_set;

  // Writes to r0 are dropped here so they neither update the array nor retire.
  always_comb begin
    wr_act = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wa[w]     = waddr[w*ADDR_W +: ADDR_W];
      wd[w]     = wdata[w*DATA_W +: DATA_W];
      wr_act[w] = we[w] && (wa[w] != '0);
    end
  end

  // Later ports are assigned last, so the youngest write wins a collision.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_act[w]) mem[wa[w]] <= wd[w];
    end
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      dec[r] = '0;
      for (int w = 0; w < NUM_WR; w++)
        if (wr_act[w] && (wa[w] == ADDR_W'(r))) dec[r] = dec[r] + ONE;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              b;
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    d     = '0;
    b     = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      d  = mem[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++)
          if (wr_act[w] && (wa[w] == ra)) d = wd[w];
        b = ({1'b0, cnt[ra]} > dec[ra]);
      end else begin
        b = (cnt[ra] != '0);
      end
      if (ra == '0) begin
        d = '0;
        b = 1'b0;
      end
      rdata[i*DATA_W +: DATA_W] = d;
      rbusy[i] = b;
    end
  end

  // Flush overrides issue and retire, so neither can raise an error in that cycle.
  always_comb begin
    logic [CNT_W:0] sum;
    logic           inc;
    issue_ready = (cnt[issue_addr] != CNT_MAX);
    err_set     = 1'b0;
    sum         = '0;
    inc         = 1'b0;
    for (int r = 0; r < DEPTH; r++) cnt_nxt[r] = '0;
    if (!flush) begin
      if (issue_valid && !issue_ready) err_set = 1'b1;
      for (int r = 1; r < DEPTH; r++) begin
        inc = issue_valid && issue_ready && (issue_addr == ADDR_W'(r));
        sum = {1'b0, cnt[r]} + (inc ? ONE : '0);
        if (dec[r] > sum) begin
          cnt_nxt[r] = '0;
          err_set    = 1'b1;
        end else begin
          cnt_nxt[r] = CNT_W'(sum - dec[r]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= cnt_nxt[r];
      if (err_set) sb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

  assign hi_rdata = ((BYPASS != 0) && hi_we) ? hi_wdata : hi_q;
  assign lo_rdata = ((BYPASS != 0) && lo_we) ? lo_wdata : lo_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: one bypassing instance and one array-only
// instance driven by the same stimulus, checked against hand-derived expectations.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  ra0, ra1, wa0, wa1, issue_addr;
  logic [1:0]  we;
  logic [31:0] wd0, wd1, hi_wdata, lo_wdata;
  logic        issue_valid, flush, hi_we, lo_we;

  logic [63:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;
  logic        issue_ready, issue_ready_nb, sb_err, sb_err_nb;
  logic [31:0] hi_rdata, lo_rdata, hi_rdata_nb, lo_rdata_nb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) u_dut (
    .clk(clk), .resetn(resetn), .raddr({ra1, ra0}), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr({wa1, wa0}), .wdata({wd1, wd0}),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata), .sb_err(sb_err)
  );

  regfile_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .resetn(resetn), .raddr({ra1, ra0}), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we), .waddr({wa1, wa0}), .wdata({wd1, wd0}),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready_nb),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .hi_rdata(hi_rdata_nb), .lo_rdata(lo_rdata_nb), .sb_err(sb_err_nb)
  );

  typedef struct {
    string       name;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] exp0, exp1, exp0_nb;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp0, exp1, exp0_nb;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    we = 2'b00; wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'h0; wd1 = 32'h0;
    ra0 = 5'd0; ra1 = 5'd0; issue_valid = 1'b0; issue_addr = 5'd0; flush = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; hi_wdata = 32'h0; lo_wdata = 32'h0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    we = v.we; wa0 = v.wa0; wa1 = v.wa1; wd0 = v.wd0; wd1 = v.wd1;
    ra0 = v.ra0; ra1 = v.ra1;
    e.name = v.name; e.exp0 = v.exp0; e.exp1 = v.exp1; e.exp0_nb = v.exp0_nb;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      chk({e.name, "_rd0"}, rdata[31:0], e.exp0);
      chk({e.name, "_rd1"}, rdata[63:32], e.exp1);
      chk({e.name, "_rd0_nb"}, rdata_nb[31:0], e.exp0_nb);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle();
    resetn = 1'b0;
    #1 chk("rst_sb_err", 32'(sb_err), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    vecs[0] = '{"w_r0",    2'b01, 5'd0, 5'd0, 32'h1234, 32'h0,    5'd0, 5'd0, 32'h0,    32'h0,    32'h0};
    vecs[1] = '{"collide", 2'b11, 5'd7, 5'd7, 32'h11,   32'h22,   5'd7, 5'd7, 32'h22,   32'h22,   32'h0};
    vecs[2] = '{"rd_r7",   2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    5'd7, 5'd0, 32'h22,   32'h0,    32'h22};
    vecs[3] = '{"split",   2'b11, 5'd8, 5'd9, 32'hA5A5, 32'h5A5A, 5'd8, 5'd9, 32'hA5A5, 32'h5A5A, 32'h0};
    vecs[4] = '{"rd_89",   2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    5'd9, 5'd8, 32'h5A5A, 32'hA5A5, 32'h5A5A};
    vecs[5] = '{"p1_r7",   2'b10, 5'd8, 5'd7, 32'hFFFF, 32'h33,   5'd7, 5'd8, 32'h33,   32'hA5A5, 32'h22};
    vecs[6] = '{"p0_only", 2'b01, 5'd8, 5'd8, 32'hBEEF, 32'hCAFE, 5'd8, 5'd7, 32'hBEEF, 32'h33,   32'hA5A5};
    vecs[7] = '{"rd_fin",  2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    5'd8, 5'd7, 32'hBEEF, 32'h33,   32'hBEEF};

    // Reset held while a write is presented: bypass still shows it, array must not take it.
    idle();
    resetn = 1'b0;
    we = 2'b01; wa0 = 5'd3; wd0 = 32'hDEADBEEF; ra0 = 5'd3;
    #2;
    chk("rst_rd_bypass", rdata[31:0], 32'hDEADBEEF);
    chk("rst_rd_nb", rdata_nb[31:0], 32'h0);
    chk("rst_rbusy", 32'(rbusy), 32'h0);
    chk("rst_issue_ready", 32'(issue_ready), 32'h1);
    chk("rst_sb_err", 32'(sb_err), 32'h0);
    chk("rst_hi", hi_rdata, 32'h0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    we = 2'b00; resetn = 1'b1;
    #1 chk("post_rst_r3", rdata[31:0], 32'h0);
    @(negedge clk);
    we = 2'b01; wa0 = 5'd0; wd0 = 32'h1234; ra0 = 5'd0;
    #1 chk("r0_same", rdata[31:0], 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("r0_after", rdata[31:0], 32'h0);
    chk("r0_no_err", 32'(sb_err), 32'h0);
    chk("r0_ready", 32'(issue_ready), 32'h1);
    @(negedge clk);

    // Scoreboard fill to saturation on r5.
    ra0 = 5'd5; issue_valid = 1'b1; issue_addr = 5'd5;
    #1 chk("iss1_rbusy", 32'(rbusy[0]), 32'h0);
    chk("iss1_ready", 32'(issue_ready), 32'h1);
    @(negedge clk);
    #1 chk("iss2_rbusy", 32'(rbusy[0]), 32'h1);
    @(negedge clk);
    #1 chk("iss3_ready", 32'(issue_ready), 32'h1);
    @(negedge clk);
    #1;
    chk("iss4_ready", 32'(issue_ready), 32'h0);
    chk("iss4_ready_nb", 32'(issue_ready_nb), 32'h0);
    chk("iss4_err_pre", 32'(sb_err), 32'h0);
    @(negedge clk);
    issue_valid = 1'b0;
    #1 chk("full_err", 32'(sb_err), 32'h1);
    chk("full_rbusy", 32'(rbusy[0]), 32'h1);
    we = 2'b01; wa0 = 5'd5; wd0 = 32'h100;
    #1 chk("ret1_rbusy", 32'(rbusy[0]), 32'h1);
    chk("ret1_rd", rdata[31:0], 32'h100);
    @(negedge clk);
    wd0 = 32'h200;
    #1 chk("ret2_rbusy", 32'(rbusy[0]), 32'h1);
    @(negedge clk);
    wd0 = 32'h300;
    #1 chk("ret3_rbusy", 32'(rbusy[0]), 32'h0);
    chk("ret3_rd", rdata[31:0], 32'h300);
    chk("ret3_rbusy_nb", 32'(rbusy_nb[0]), 32'h1);
    chk("ret3_rd_nb", rdata_nb[31:0], 32'h200);
    @(negedge clk);
    we = 2'b00;
    #1 chk("ret_done_rbusy_nb", 32'(rbusy_nb[0]), 32'h0);
    @(negedge clk);

    // Two retires to one register in a single cycle.
    ra0 = 5'd11; issue_valid = 1'b1; issue_addr = 5'd11;
    @(negedge clk);
    @(negedge clk);
    issue_valid = 1'b0; we = 2'b11; wa0 = 5'd11; wa1 = 5'd11; wd0 = 32'h1; wd1 = 32'h2;
    #1 chk("dual_ret_rbusy", 32'(rbusy[0]), 32'h0);
    chk("dual_ret_rbusy_nb", 32'(rbusy_nb[0]), 32'h1);
    @(negedge clk);
    idle(); ra0 = 5'd11;
    #1 chk("dual_ret_after", 32'(rbusy_nb[0]), 32'h0);
    @(negedge clk);

    // Simultaneous issue and retire on r9 keeps its count.
    ra0 = 5'd9; issue_valid = 1'b1; issue_addr = 5'd9;
    @(negedge clk);
    we = 2'b01; wa0 = 5'd9; wd0 = 32'h99;
    #1 chk("sim_rbusy_nb", 32'(rbusy_nb[0]), 32'h1);
    @(negedge clk);
    idle(); ra0 = 5'd9;
    #1 chk("sim_after_rbusy", 32'(rbusy[0]), 32'h1);
    chk("sim_after_rd", rdata[31:0], 32'h99);
    @(negedge clk);
    we = 2'b01; wa0 = 5'd9; wd0 = 32'h9A;
    #1 chk("sim_last_ret", 32'(rbusy[0]), 32'h0);
    @(negedge clk);
    idle(); ra0 = 5'd9;
    #1 chk("sim_cleared", 32'(rbusy_nb[0]), 32'h0);

    // Flush clears counters but lets the data write through.
    pulse_reset();
    issue_valid = 1'b1; issue_addr = 5'd4;
    @(negedge clk);
    @(negedge clk);
    issue_addr = 5'd6;
    @(negedge clk);
    issue_valid = 1'b0; ra0 = 5'd4; ra1 = 5'd6;
    #1 chk("pre_flush_rbusy", 32'(rbusy), 32'h3);
    flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd4;
    we = 2'b01; wa0 = 5'd6; wd0 = 32'h66;
    @(negedge clk);
    idle(); ra0 = 5'd4; ra1 = 5'd6;
    #1 chk("flush_rbusy", 32'(rbusy), 32'h0);
    chk("flush_rbusy_nb", 32'(rbusy_nb), 32'h0);
    chk("flush_data", rdata[63:32], 32'h66);
    chk("flush_err", 32'(sb_err), 32'h0);

    // Table of read/write vectors; unscoreboarded writes underflow and set sb_err.
    pulse_reset();
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k]);
      #1 checkOutput();
      @(negedge clk);
    end
    idle();
    #1 chk("underflow_err", 32'(sb_err), 32'h1);
    chk("underflow_err_nb", 32'(sb_err_nb), 32'h1);
    @(negedge clk);

    // HI/LO independence and async clear.
    lo_we = 1'b1; lo_wdata = 32'h5555;
    #1 chk("lo_bypass", lo_rdata, 32'h5555);
    chk("lo_nb_old", lo_rdata_nb, 32'h0);
    @(negedge clk);
    lo_we = 1'b0; hi_we = 1'b1; hi_wdata = 32'hAAAA0000;
    #1 chk("hi_bypass", hi_rdata, 32'hAAAA0000);
    chk("hi_nb_old", hi_rdata_nb, 32'h0);
    chk("lo_hold", lo_rdata, 32'h5555);
    @(negedge clk);
    hi_we = 1'b0; ra0 = 5'd7;
    #1 chk("hi_reg_nb", hi_rdata_nb, 32'hAAAA0000);
    chk("lo_reg_nb", lo_rdata_nb, 32'h5555);
    #1 resetn = 1'b0;
    #1 chk("async_hi", hi_rdata, 32'h0);
    chk("async_lo", lo_rdata, 32'h0);
    chk("async_r7", rdata[31:0], 32'h0);
    chk("async_err", 32'(sb_err), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write GPR file and standalone HI/LO register.
- Contents: GPR array with NUM_RD read ports and NUM_WR write ports; optional write-to-read bypass; HI/LO pair with its own bypass; per-register pending-write scoreboard.
- Sits between ID (reads, hazard query, issue marking) and WB (writes/retire); replaces the ad-hoc forwarding and stall muxes in ID.

Parameters:
- DATA_W, 32, GPR and HI/LO data width
- ADDR_W, 5, GPR address width; depth = 2**ADDR_W; entry 0 is hard-wired zero
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 2, write ports (1..2); higher index is younger
- CNT_W, 2, pending counter width per register; max = 2**CNT_W-1
- BYPASS, 1, 1 = same-cycle write data visible on reads; 0 = array only

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- raddr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, combinational
- rbusy  out  NUM_RD  read register has an outstanding write not satisfied this cycle
- we  in  NUM_WR  write enables
- waddr  in  NUM_WR*ADDR_W  write addresses
- wdata  in  NUM_WR*DATA_W  write data
- issue_valid  in  1  mark issue_addr as having one more pending write
- issue_addr  in  ADDR_W  destination being issued
- issue_ready  out  1  issue_addr counter below max (combinational)
- flush  in  1  clear all pending counters
- hi_we, lo_we  in  1 each  HI/LO write enables
- hi_wdata, lo_wdata  in  DATA_W each  HI/LO write data
- hi_rdata, lo_rdata  out  DATA_W each  HI/LO read data
- sb_err  out  1  sticky: retire at count 0 or issue while full

Behaviour:
- Reset (resetn low, async): all GPR entries, HI, LO, all pending counters, and sb_err cleared to 0.
- Outputs during reset follow the combinational rules on the cleared state: rdata = 0 unless bypassed, rbusy = 0, issue_ready = 1, hi_rdata/lo_rdata = 0 unless bypassed.
- Reset release is mid-operation safe: no state survives.
- Writes: on a clk edge, each port with we=1 and waddr!=0 updates its entry.
- Writes, same address on both ports: port NUM_WR-1 wins.
- Writes to address 0 are discarded and count as no retire.
- Reads, latency 0:
  - raddr==0 -> rdata = 0.
  - BYPASS=1 and a matching active write this cycle -> rdata = wdata of the highest-index matching port.
  - Otherwise rdata = array contents.
- HI/LO: registered on clk edge when the respective enable is set.
- HI/LO read, BYPASS=1: hi_rdata = hi_we ? hi_wdata : HI; lo_rdata likewise.
- HI/LO read, BYPASS=0: registered value only.
- HI and LO are independent; one may be written without the other.
- Scoreboard, per register r != 0:
  - inc = issue_valid && issue_addr==r && issue_ready.
  - dec = number of write ports with we && waddr==r (0..NUM_WR).
  - next = cnt + inc - dec, clamped at 0.
- Register 0 counter is constant 0; issue to address 0 is accepted and has no effect.
- Underflow (dec > cnt+inc): counter becomes 0 and sb_err sets.
- Issue while full: issue_ready=0, issue is ignored, and sb_err sets.
- Simultaneous issue and single retire on the same register: counter unchanged.
- flush=1: all counters become 0 next edge, overriding issue and retire that cycle. GPR/HI/LO writes in the same cycle still commit. sb_err is unaffected.
- rbusy[i], raddr==0: 0.
- rbusy[i], BYPASS=1: (cnt - dec_this_cycle) != 0, using a saturating subtract. If the last pending write lands this cycle, the read is not busy and gets bypassed data.
- rbusy[i], BYPASS=0: cnt != 0, registered value only.
- Issue marking does not affect rbusy in the same cycle.
- sb_err clears only on reset.

Test Plan:
- Reset and zero register: resetn low while we[0]=1, waddr=3, wdata=0xDEADBEEF -> after release, raddr=3 reads 0. Then write 0x1234 to r0 -> r0 reads 0 and no counter change.
- Dual-write collision: we=2'b11, both waddr=7, wdata0=0x11, wdata1=0x22 -> same-cycle rdata=0x22 (BYPASS=1); array holds 0x22 next cycle. Repeat with BYPASS=0 -> same-cycle read returns the old value.
- Scoreboard: issue r5 three times (CNT_W=2) -> issue_ready=0 on the fourth attempt, sb_err=1, rbusy=1. Three retires to r5 -> on the third retire cycle rbusy=0 and rdata = retiring data.
- Simultaneous events: cnt[9]=1 with issue r9 and write r9 in the same cycle -> cnt[9] stays 1, rbusy stays 1.
- Flush: cnt[4]=2, cnt[6]=1, flush with issue r4 -> all counters 0 next cycle. A write to r6 in the flush cycle commits its data; sb_err unchanged.
- HI/LO: hi_we=1, hi_wdata=0xAAAA0000, lo_we=0 -> hi_rdata=0xAAAA0000 same cycle, lo_rdata holds its prior value. Assert resetn=0 mid-sequence -> both read 0 immediately.
